// File: rtl/dec2_sync_pkg.sv
// Shared constants, types and reference decode function for the dec2_sync decoder.
// No logic of its own: a pure declaration package.
// No flow control.
package dec2_sync_pkg;

    // Default select width: the 2-to-4 configuration.
    localparam int IN_W_DEF  = 2;

    // Widest supported select, and the decode width that goes with it.
    localparam int MAX_IN_W  = 6;
    localparam int MAX_OUT_W = 2 ** MAX_IN_W;

    // How a dec2_core instance builds its decode.
    typedef enum logic {
        DEC_DATAFLOW = 1'b0,
        DEC_BEHAV    = 1'b1
    } dec_style_e;

    // Reference one-hot decode at the widest size; callers keep the low OUT_W bits.
    function automatic logic [MAX_OUT_W-1:0] onehot_dec(input logic [MAX_IN_W-1:0] sel,
                                                        input logic                en);
        logic [MAX_OUT_W-1:0] r;
        r = '0;
        if (en) begin
            r[sel] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dec2_sync_if.sv
// Bus bundle for dec2_sync: select/enable in, registered decode/valid/err out.
// Wiring only; no latency of its own.
// No backpressure: the decoder accepts a new sample every cycle.
interface dec2_sync_if import dec2_sync_pkg::*; #(
    parameter int IN_W = IN_W_DEF
);
    localparam int OUT_W = 2 ** IN_W;

    logic [IN_W-1:0]  i_in;
    logic             i_en;
    logic [OUT_W-1:0] o_out;
    logic             o_valid;
    logic             o_err;

    // Driver side: supplies the select and enable, observes the results.
    modport master (
        output i_in,
        output i_en,
        input  o_out,
        input  o_valid,
        input  o_err
    );

    // Decoder side.
    modport slave (
        input  i_in,
        input  i_en,
        output o_out,
        output o_valid,
        output o_err
    );
endinterface

// File: rtl/dec2_sync_core.sv
// Combinational N-to-2^N one-hot decoder, built as either a dataflow or a behavioural netlist.
// Zero latency: purely combinational.
// No flow control.
module dec2_core import dec2_sync_pkg::*; #(
    parameter int         IN_W  = IN_W_DEF,
    parameter dec_style_e STYLE = DEC_BEHAV
) (
    input  logic [IN_W-1:0]      i_sel,
    input  logic                 i_en,
    output logic [2**IN_W-1:0]   o_dec
);
    localparam int OUT_W = 2 ** IN_W;

    logic [OUT_W-1:0] w_dec;

    if (STYLE == DEC_DATAFLOW) begin : g_dataflow
        // Each line is the enable ANDed with the minterm of its own index.
        for (genvar g = 0; g < OUT_W; g++) begin : g_line
            assign w_dec[g] = i_en & (&(i_sel ~^ IN_W'(g)));
        end
    end else begin : g_behav
        // Clear all lines, then raise the one addressed by the select.
        always_comb begin
            w_dec = '0;
            if (i_en) begin
                w_dec[i_sel] = 1'b1;
            end
        end
    end

    assign o_dec = w_dec;

endmodule

// File: rtl/dec2_sync.sv
// Registered N-to-2^N one-hot decoder with enable; optional dual-path cross-check (DEC2_SYNC_XCHECK_EN).
// Latency: 1 cycle from sampled select/enable to o_out/o_valid/o_err.
// No backpressure: a new sample is taken every cycle and only the latest one is shown.
module dec2_sync import dec2_sync_pkg::*; #(
    parameter int IN_W = IN_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    dec2_sync_if.slave   bus
);
    localparam int OUT_W = 2 ** IN_W;

    logic [OUT_W-1:0] w_dec_behav;
    logic             w_mismatch;

    logic [OUT_W-1:0] r_out;
    logic             r_valid;
    logic             r_err;

    // The behavioural path always feeds the output register.
    dec2_core #(
        .IN_W  (IN_W),
        .STYLE (DEC_BEHAV)
    ) u_core_behav (
        .i_sel (bus.i_in),
        .i_en  (bus.i_en),
        .o_dec (w_dec_behav)
    );

`ifdef DEC2_SYNC_XCHECK_EN
    logic [OUT_W-1:0] w_dec_flow;

    // Independent dataflow decode, used only to cross-check the behavioural one.
    dec2_core #(
        .IN_W  (IN_W),
        .STYLE (DEC_DATAFLOW)
    ) u_core_flow (
        .i_sel (bus.i_in),
        .i_en  (bus.i_en),
        .o_dec (w_dec_flow)
    );

    assign w_mismatch = (w_dec_flow != w_dec_behav);
`else
    assign w_mismatch = 1'b0;
`endif

    // Output register: clears on reset, otherwise captures the decode; err is sticky until reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_out   <= w_dec_behav;
            r_valid <= bus.i_en;
            r_err   <= r_err | w_mismatch;
        end
    end

    assign bus.o_out   = r_out;
    assign bus.o_valid = r_valid;
    assign bus.o_err   = r_err;

endmodule

// File: tb/tb_dec2_sync.sv
// Self-checking bench for dec2_sync: directed vector table, mid-stream reset sequence, random soak.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the next rising edge.
// The DUT has no backpressure, so every cycle is one applied sample.
module tb_dec2_sync;
    import dec2_sync_pkg::*;

    localparam int IN_W  = 2;
    localparam int OUT_W = 4;

    logic i_clk;
    logic i_rst;

    dec2_sync_if #(.IN_W(IN_W)) bus ();

    dec2_sync #(.IN_W(IN_W)) u_dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    // 100 ns clock period.
    initial i_clk = 1'b0;
    always #50 i_clk = ~i_clk;

    int n_vec;
    int n_bad;

    typedef struct {
        string            name;
        logic             rst;
        logic [IN_W-1:0]  in;
        logic             en;
        logic [OUT_W-1:0] exp_out;
        logic             exp_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one sample, let one rising edge capture it, then settle.
    task automatic step(input logic rst, input logic [IN_W-1:0] in, input logic en);
        i_rst    = rst;
        bus.i_in = in;
        bus.i_en = en;
        @(posedge i_clk);
        #1;
    endtask

    task automatic add(input string name, input logic rst, input logic [IN_W-1:0] in,
                       input logic en, input logic [OUT_W-1:0] exp_out, input logic exp_valid);
        vec_t v;
        v.name = name; v.rst = rst; v.in = in; v.en = en;
        v.exp_out = exp_out; v.exp_valid = exp_valid;
        vecs.push_back(v);
    endtask

    logic [MAX_OUT_W-1:0] ref_full;
    logic [OUT_W-1:0]     exp_q[$];
    logic                 expv_q[$];

    initial begin
        n_vec = 0;
        n_bad = 0;
        i_rst    = 1'b1;
        bus.i_in = '0;
        bus.i_en = 1'b0;
        #1;

        // Reset held 3 cycles with an active decode request at the input.
        add("rst0", 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0);
        add("rst1", 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0);
        add("rst2", 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0);
        // Enabled sweep over every select value.
        add("sweep0", 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1);
        add("sweep1", 1'b0, 2'd1, 1'b1, 4'b0010, 1'b1);
        add("sweep2", 1'b0, 2'd2, 1'b1, 4'b0100, 1'b1);
        add("sweep3", 1'b0, 2'd3, 1'b1, 4'b1000, 1'b1);
        // Disabled: select is ignored.
        add("dis0", 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        add("dis1", 1'b0, 2'd1, 1'b0, 4'b0000, 1'b0);
        add("dis2", 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0);
        add("dis3", 1'b0, 2'd3, 1'b0, 4'b0000, 1'b0);
        // Select and enable change together: 1000 must never appear.
        add("simul_a", 1'b0, 2'd1, 1'b1, 4'b0010, 1'b1);
        add("simul_b", 1'b0, 2'd3, 1'b0, 4'b0000, 1'b0);
        add("simul_c", 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].in, vecs[i].en);
            chk({vecs[i].name, ".out"},   32'(bus.o_out),   32'(vecs[i].exp_out));
            chk({vecs[i].name, ".valid"}, 32'(bus.o_valid), 32'(vecs[i].exp_valid));
            chk({vecs[i].name, ".err"},   32'(bus.o_err),   32'd0);
        end

        // Reset pulse in the middle of a steady enabled stream: 0100, 0000, 0100.
        step(1'b0, 2'd2, 1'b1);
        chk("midrst.before", 32'(bus.o_out), 32'h4);
        step(1'b1, 2'd2, 1'b1);
        chk("midrst.during", 32'(bus.o_out), 32'h0);
        chk("midrst.during_valid", 32'(bus.o_valid), 32'd0);
        step(1'b0, 2'd2, 1'b1);
        chk("midrst.after", 32'(bus.o_out), 32'h4);
        chk("midrst.after_valid", 32'(bus.o_valid), 32'd1);

        // Random soak: reference decode queued one cycle ahead of the output.
        for (int c = 0; c < 40; c++) begin
            logic [2:0] r;
            r = 3'($urandom_range(0, 7));
            ref_full = onehot_dec({4'b0000, r[1:0]}, r[2]);
            exp_q.push_back(ref_full[OUT_W-1:0]);
            expv_q.push_back(r[2]);
            step(1'b0, r[1:0], r[2]);
            chk("soak.out",     32'(bus.o_out),            32'(exp_q.pop_front()));
            chk("soak.valid",   32'(bus.o_valid),          32'(expv_q.pop_front()));
            chk("soak.onehot0", 32'($onehot0(bus.o_out)),  32'd1);
            chk("soak.err",     32'(bus.o_err),            32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
